// File: rtl/noc_outport_arb_if.sv
// Bundles the input-buffer request side and the downstream link side of one
// router output port. The arbiter takes the slave view; the driver of flits takes master.
interface noc_outport_arb_if #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 288,
  parameter int CREDITS    = 4
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(CREDITS + 1);

  // Request side: one flit slot per input buffer, plus the combinational pop.
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_ports;
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_last;
  logic [NUM_PORTS-1:0]            ports_clear;

  // Link side: registered flit, credit flow control and lock status.
  logic [DATA_WIDTH-1:0]           port_out;
  logic                            out_valid;
  logic                            out_last;
  logic                            credit_return;
  logic [CW-1:0]                   credits_avail;
  logic                            locked;
  logic [PW-1:0]                   lock_owner;
  logic                            credit_err;

  modport master (
    output in_ports, in_valid, in_last, credit_return,
    input  ports_clear, port_out, out_valid, out_last,
           credits_avail, locked, lock_owner, credit_err
  );

  modport slave (
    input  in_ports, in_valid, in_last, credit_return,
    output ports_clear, port_out, out_valid, out_last,
           credits_avail, locked, lock_owner, credit_err
  );
endinterface

// File: rtl/noc_outport_arb.sv
// Round-robin output-port arbiter with wormhole packet lock and credit-based
// downstream flow control; forwards at most one flit per cycle.
module noc_outport_arb #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 288,
  parameter int CREDITS    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  noc_outport_arb_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         lock_owner_q;
  logic [CW-1:0]         credits_q;
  logic                  credit_err_q;
  logic [DATA_WIDTH-1:0] port_out_q;
  logic                  out_valid_q;
  logic                  out_last_q;

  logic                  can_send;
  logic                  cred_full;
  logic                  scan_hit;
  logic [PW-1:0]         scan_idx;
  logic [PW:0]           scan_pos;
  logic                  grant;
  logic [PW-1:0]         grant_idx;
  logic                  grant_last;
  logic [DATA_WIDTH-1:0] grant_flit;
  logic [PW:0]           ptr_inc;
  logic [PW-1:0]         rr_next;

  // A return arriving this cycle is not usable until the counter has absorbed it.
  assign can_send  = (credits_q != '0);
  assign cred_full = (credits_q == CW'(CREDITS));

  // Scan from rr_ptr upward with wrap; iterating from the far end lets the
  // nearest requester overwrite the others and win.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    scan_hit = 1'b0;
    scan_idx = '0;
    scan_pos = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      scan_pos = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_pos >= (PW+1)'(NUM_PORTS)) begin
        scan_pos = scan_pos - (PW+1)'(NUM_PORTS);
      end
      if (bus.in_valid[scan_pos[PW-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = scan_pos[PW-1:0];
      end
    end
  end

  // FSM output process: who is granted this cycle and the one-hot pop.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (rst_n && can_send) begin
      if (state == LOCKED) begin
        grant     = bus.in_valid[lock_owner_q];
        grant_idx = lock_owner_q;
      end else begin
        grant     = scan_hit;
        grant_idx = scan_idx;
      end
    end
    grant_last      = bus.in_last[grant_idx];
    bus.ports_clear = '0;
    if (grant) begin
      bus.ports_clear[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    grant_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == PW'(i)) begin
        grant_flit = bus.in_ports[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer after a tail grant: one past the winner, wrapping in PW+1 bits.
  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (PW+1)'(1);
    rr_next = (ptr_inc == (PW+1)'(NUM_PORTS)) ? '0 : ptr_inc[PW-1:0];
  end

  // FSM next-state process.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant && !grant_last) state_next = LOCKED;
      LOCKED:  if (grant &&  grant_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the flit register is reset too, so the link shows a defined zero flit after reset.
    if (!rst_n) begin
      rr_ptr       <= '0;
      lock_owner_q <= '0;
      port_out_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      out_valid_q <= grant;
      if (grant) begin
        port_out_q <= grant_flit;
        out_last_q <= grant_last;
        if (grant_last) begin
          rr_ptr <= rr_next;
        end else begin
          lock_owner_q <= grant_idx;
        end
      end
    end
  end

  // Credits: one consumed per forwarded flit, one restored per return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits_q    <= CW'(CREDITS);
      credit_err_q <= 1'b0;
    end else if (bus.credit_return && !grant && cred_full) begin
      credit_err_q <= 1'b1;
    end else begin
      credits_q <= credits_q + CW'(bus.credit_return) - CW'(grant);
    end
  end

  assign bus.port_out      = port_out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.credits_avail = credits_q;
  assign bus.locked        = (state == LOCKED);
  assign bus.lock_owner    = lock_owner_q;
  assign bus.credit_err    = credit_err_q;

  a_pop_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.ports_clear));
  a_cred_range : assert property (@(posedge clk) disable iff (!rst_n) credits_q <= CW'(CREDITS));
endmodule

// File: tb/tb_noc_outport_arb.sv
// Bench for noc_outport_arb: directed vector table, hand sequences for credit,
// bubble and reset corners, then random traffic against a reference model.
module tb_noc_outport_arb;
  localparam int NP = 5;
  localparam int DW = 288;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_outport_arb_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CREDITS(CR)) bus ();

  noc_outport_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .CREDITS(CR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int tag   = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit_of(input int p, input int t);
    logic [DW-1:0] f;
    f = '0;
    f[7:0]          = 8'(p);
    f[23:8]         = 16'(t);
    f[DW-1 -: 16]   = 16'(t) ^ 16'h5a5a;
    f[DW-17 -: 8]   = 8'(p) ^ 8'hc3;
    return f;
  endfunction

  // Reference model: output port as a credit pool, a round-robin pointer and an optional lock holder.
  int            m_rr = 0, m_owner = 0, m_cred = CR;
  bit            m_locked = 0, m_err = 0, m_ov = 0, m_ol = 0;
  logic [DW-1:0] m_out = '0;

  function automatic int m_pick();
    if (!rst_n || m_cred == 0) return -1;
    if (m_locked) return bus.in_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_rr + k) % NP;
      if (bus.in_valid[p]) return p;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs at the falling edge, observe the pop, step past the
  // rising edge and return at the next falling edge with registered outputs settled.
  task automatic apply(input bit r, input logic [NP-1:0] v, input logic [NP-1:0] l,
                       input bit c, output logic [NP-1:0] clr_seen);
    int w;
    logic [NP-1:0] exp_clr;
    rst_n = r;
    bus.in_valid = v;
    bus.in_last = l;
    bus.credit_return = c;
    for (int i = 0; i < NP; i++) bus.in_ports[i*DW +: DW] = flit_of(i, tag);
    #1;
    clr_seen = bus.ports_clear;
    w = m_pick();
    exp_clr = '0;
    if (w >= 0) exp_clr[w] = 1'b1;
    if (model_on) check("model ports_clear", DW'(clr_seen), DW'(exp_clr));
    @(posedge clk);
    if (!r) begin
      m_rr = 0; m_owner = 0; m_cred = CR; m_locked = 0; m_err = 0;
      m_ov = 0; m_ol = 0; m_out = '0;
    end else begin
      m_ov = (w >= 0);
      if (w >= 0) begin
        m_out = flit_of(w, tag);
        m_ol  = l[w];
        if (l[w]) begin
          m_locked = 0;
          m_rr = (w + 1) % NP;
        end else begin
          m_locked = 1;
          m_owner = w;
        end
      end
      if (c && w < 0 && m_cred == CR) m_err = 1;
      else m_cred = m_cred + int'(c) - ((w >= 0) ? 1 : 0);
    end
    @(negedge clk);
    if (model_on) begin
      check("model out_valid", DW'(bus.out_valid), DW'(m_ov));
      check("model credits", DW'(bus.credits_avail), DW'(m_cred));
      check("model locked", DW'(bus.locked), DW'(m_locked));
      check("model lock_owner", DW'(bus.lock_owner), DW'(m_owner));
      check("model credit_err", DW'(bus.credit_err), DW'(m_err));
      if (m_ov) begin
        check("model port_out", bus.port_out, m_out);
        check("model out_last", DW'(bus.out_last), DW'(m_ol));
      end
    end
  endtask

  // own < 0 skips the owner comparison; src and ol are only compared on a valid flit.
  task automatic chk(input string nm, input logic [NP-1:0] clr, input logic [NP-1:0] exp_clr,
                     input bit ov, input int src, input bit ol, input bit lk,
                     input int own, input int cred);
    check($sformatf("%s ports_clear", nm), DW'(clr), DW'(exp_clr));
    check($sformatf("%s out_valid", nm), DW'(bus.out_valid), DW'(ov));
    if (ov) begin
      check($sformatf("%s port_out", nm), bus.port_out, flit_of(src, tag));
      check($sformatf("%s out_last", nm), DW'(bus.out_last), DW'(ol));
    end
    check($sformatf("%s locked", nm), DW'(bus.locked), DW'(lk));
    if (own >= 0) check($sformatf("%s lock_owner", nm), DW'(bus.lock_owner), DW'(own));
    check($sformatf("%s credits", nm), DW'(bus.credits_avail), DW'(cred));
  endtask

  typedef struct {
    bit            r;
    logic [NP-1:0] v;
    logic [NP-1:0] l;
    bit            c;
    logic [NP-1:0] clr;
    bit            ov;
    int            src;
    bit            ol;
    bit            lk;
    int            own;
    int            cred;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] clr;

    bus.in_ports = '0;
    bus.in_valid = '0;
    bus.in_last = '0;
    bus.credit_return = 1'b0;

    // Round-robin over five single-flit requesters, then a 3-flit packet on port 2.
    tbl[0]  = '{1'b0, 5'h1f, 5'h1f, 1'b1, 5'h00, 1'b0, 0, 1'b0, 1'b0, 0, 4};
    tbl[1]  = '{1'b1, 5'h1f, 5'h1f, 1'b1, 5'h01, 1'b1, 0, 1'b1, 1'b0, 0, 4};
    tbl[2]  = '{1'b1, 5'h1f, 5'h1f, 1'b1, 5'h02, 1'b1, 1, 1'b1, 1'b0, 0, 4};
    tbl[3]  = '{1'b1, 5'h1f, 5'h1f, 1'b1, 5'h04, 1'b1, 2, 1'b1, 1'b0, 0, 4};
    tbl[4]  = '{1'b1, 5'h1f, 5'h1f, 1'b1, 5'h08, 1'b1, 3, 1'b1, 1'b0, 0, 4};
    tbl[5]  = '{1'b1, 5'h1f, 5'h1f, 1'b1, 5'h10, 1'b1, 4, 1'b1, 1'b0, 0, 4};
    tbl[6]  = '{1'b1, 5'h1f, 5'h1f, 1'b1, 5'h01, 1'b1, 0, 1'b1, 1'b0, 0, 4};
    tbl[7]  = '{1'b1, 5'h02, 5'h1f, 1'b1, 5'h02, 1'b1, 1, 1'b1, 1'b0, 0, 4};
    tbl[8]  = '{1'b1, 5'h0f, 5'h0b, 1'b1, 5'h04, 1'b1, 2, 1'b0, 1'b1, 2, 4};
    tbl[9]  = '{1'b1, 5'h0f, 5'h0b, 1'b1, 5'h04, 1'b1, 2, 1'b0, 1'b1, 2, 4};
    tbl[10] = '{1'b1, 5'h0f, 5'h0f, 1'b1, 5'h04, 1'b1, 2, 1'b1, 1'b0, 2, 4};
    tbl[11] = '{1'b1, 5'h0b, 5'h0b, 1'b1, 5'h08, 1'b1, 3, 1'b1, 1'b0, 2, 4};

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].c, clr);
      chk($sformatf("vec%0d", i), clr, tbl[i].clr, tbl[i].ov, tbl[i].src, tbl[i].ol,
          tbl[i].lk, tbl[i].own, tbl[i].cred);
    end
    check("vec credit_err", DW'(bus.credit_err), DW'(0));

    // Credit exhaustion: four flits, a stall, then one return buys exactly one flit.
    for (int k = 0; k < 4; k++) begin
      apply(1, 5'h10, 5'h10, 0, clr);
      chk($sformatf("drain%0d", k), clr, 5'h10, 1, 4, 1, 0, -1, 3 - k);
    end
    apply(1, 5'h10, 5'h10, 0, clr);
    chk("starved", clr, 5'h00, 0, 0, 0, 0, -1, 0);
    apply(1, 5'h10, 5'h10, 1, clr);
    chk("return_at_zero", clr, 5'h00, 0, 0, 0, 0, -1, 1);
    apply(1, 5'h10, 5'h10, 0, clr);
    chk("one_more", clr, 5'h10, 1, 4, 1, 0, -1, 0);
    apply(1, 5'h10, 5'h10, 0, clr);
    chk("starved_again", clr, 5'h00, 0, 0, 0, 0, -1, 0);

    // Reset, then a locked owner bubbles for two cycles while port 0 waits.
    apply(0, 5'h00, 5'h00, 0, clr);
    chk("reset", clr, 5'h00, 0, 0, 0, 0, 0, 4);
    check("reset port_out", bus.port_out, '0);
    apply(1, 5'h08, 5'h00, 0, clr);
    chk("lock3", clr, 5'h08, 1, 3, 0, 1, 3, 3);
    for (int k = 0; k < 2; k++) begin
      apply(1, 5'h01, 5'h01, 0, clr);
      chk($sformatf("bubble%0d", k), clr, 5'h00, 0, 0, 0, 1, 3, 3);
    end
    apply(1, 5'h09, 5'h09, 0, clr);
    chk("owner_tail", clr, 5'h08, 1, 3, 1, 0, -1, 2);
    apply(1, 5'h01, 5'h01, 0, clr);
    chk("port0", clr, 5'h01, 1, 0, 1, 0, -1, 1);
    apply(1, 5'h01, 5'h01, 1, clr);
    chk("send_and_return", clr, 5'h01, 1, 0, 1, 0, -1, 1);
    for (int k = 0; k < 3; k++) begin
      apply(1, 5'h00, 5'h00, 1, clr);
      chk($sformatf("refill%0d", k), clr, 5'h00, 0, 0, 0, 0, -1, 2 + k);
    end
    check("no_err_at_full", DW'(bus.credit_err), DW'(0));
    apply(1, 5'h00, 5'h00, 1, clr);
    chk("overflow", clr, 5'h00, 0, 0, 0, 0, -1, 4);
    check("overflow credit_err", DW'(bus.credit_err), DW'(1));

    // Reset in the middle of a packet drops the lock and restarts at port 0.
    apply(1, 5'h04, 5'h00, 0, clr);
    chk("lock2", clr, 5'h04, 1, 2, 0, 1, 2, 3);
    apply(0, 5'h1f, 5'h1f, 0, clr);
    chk("mid_reset", clr, 5'h00, 0, 0, 0, 0, 0, 4);
    check("mid_reset port_out", bus.port_out, '0);
    check("mid_reset credit_err", DW'(bus.credit_err), DW'(0));
    apply(1, 5'h1f, 5'h1f, 0, clr);
    chk("after_reset", clr, 5'h01, 1, 0, 1, 0, -1, 3);

    // Random traffic against the model, with occasional resets.
    model_on = 1'b1;
    apply(0, 5'h00, 5'h00, 0, clr);
    for (int n = 0; n < 3000; n++) begin
      bit r;
      bit c;
      logic [NP-1:0] v;
      logic [NP-1:0] l;
      tag = n + 1;
      r = ($urandom_range(0, 99) != 0);
      v = NP'($urandom);
      l = NP'($urandom | $urandom);
      c = 1'($urandom_range(0, 1));
      apply(r, v, l, c, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_outport_arb.md
# noc_outport_arb

Parametrised NoC output-port arbiter for the router, between the per-direction input buffers and the link to the neighbouring router (or local sink). It grants one of NUM_PORTS requesters per cycle using a fair round-robin. A granted multi-flit packet holds the lock until its tail flit. Downstream backpressure uses credits instead of a busy level, so the link can run one flit per cycle without bubbles.

## Interface
- NUM_PORTS, 5, number of requesting input ports (index 0..4 = N, E, S, W, Local at default)
- DATA_WIDTH, 288, flit width in bits
- CREDITS, 4, downstream buffer depth; initial and maximum credit count
- Derived: PW = $clog2(NUM_PORTS), CW = $clog2(CREDITS+1)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_ports  in  NUM_PORTS*DATA_WIDTH  flattened flits; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  NUM_PORTS  port i holds a flit routed to this output
- in_last  in  NUM_PORTS  flit on port i is a packet tail (single-flit packet: in_last=1)
- ports_clear  out  NUM_PORTS  combinational one-hot pop; flit on that port is consumed at this edge
- port_out  out  DATA_WIDTH  registered output flit
- out_valid  out  1  registered; port_out valid this cycle (one pulse per flit)
- out_last  out  1  registered tail marker accompanying port_out
- credit_return  in  1  downstream freed one slot (one credit per cycle max)
- credits_avail  out  CW  current credit count
- locked  out  1  a packet is mid-transfer
- lock_owner  out  PW  port holding the lock (valid when locked=1)
- credit_err  out  1  sticky; credit_return received with count already at CREDITS

## Operation
- States: IDLE, LOCKED.
- can_send = (credits_avail != 0). A credit_return in the same cycle does not count toward can_send.
- IDLE, can_send=1:
  - winner = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, … mod NUM_PORTS.
  - ports_clear[winner]=1 that cycle.
  - Next edge: port_out<=flit, out_last<=in_last[winner], out_valid<=1.
  - If in_last[winner]=1: stay IDLE, rr_ptr <= (winner+1) mod NUM_PORTS.
  - Else: go to LOCKED with lock_owner<=winner.
- IDLE, no valid input or can_send=0: ports_clear=0, out_valid<=0, rr_ptr unchanged. The pointer moves only on a tail grant, not every cycle.
- LOCKED: only lock_owner is considered; other ports are ignored even if valid.
  - Owner valid and can_send=1: forward as above.
  - On a forwarded tail flit: go to IDLE, rr_ptr <= (owner+1) mod NUM_PORTS.
  - Owner not valid (bubble) or can_send=0: out_valid<=0, stay LOCKED.
- Credit counter next = cnt − send + credit_return:
  - send and return in the same cycle: count unchanged.
  - Return at cnt=CREDITS with no send: count held, credit_err<=1 until reset.
- port_out holds its last value when out_valid=0.
- Modulo wrap: with rr_ptr=NUM_PORTS−1, the scan continues at 0. Arithmetic is done in PW+1 bits, so non-power-of-two NUM_PORTS is legal.

## Timing
- Reset (rst_n=0 at edge), all take effect next edge:
  - port_out=0, out_valid=0, out_last=0
  - credits_avail=CREDITS, locked=0, lock_owner=0, credit_err=0
  - rr_ptr=0, state IDLE
- ports_clear is combinational from in_valid, rr_ptr, state and credits, so it is 0 during reset.
- Reset mid-packet drops the lock immediately. The packet remainder is treated as new requests.
- Latency: input flit to out_valid is 1 cycle.
- Throughput: 1 flit/cycle while credits remain. With CREDITS ≥ round-trip, back-to-back flits are sustained.
- credits_avail updates one edge after the send or return event.

## Test plan
- Reset with all 5 ports valid, single-flit packets, credit_return tied high:
  - Grants in order 0,1,2,3,4,0.
  - out_valid high every cycle from cycle 1.
  - credits_avail stays 4.
- Port 2 sends a 3-flit packet (in_last only on the 3rd) while ports 0, 1, 3 are valid:
  - Outputs are 2,2,2.
  - Next grant is 3, with locked=1 through flit 2.
  - lock_owner=2.
- No credit_return, port 4 continuously valid:
  - Exactly 4 flits sent, then out_valid=0 and ports_clear=0.
  - One credit_return pulse gives exactly one more flit.
- Send and credit_return in the same cycle at credits_avail=1:
  - Count stays 1 and no stall.
  - Extra return at count 4 sets credit_err=1 and count stays 4.
- LOCKED owner deasserts valid for 2 cycles while port 0 is valid:
  - No grant to 0, out_valid=0 for 2 cycles, then owner's flits resume.
- rst_n low mid-packet:
  - locked=0, port_out=0, credits_avail=4.
  - First grant after reset follows rr_ptr=0 priority.
